lbist_sa_sequencer: RTL
=======================

Name: lbist_sa_sequencer

Overview:
Sequences the stuck-at (SA) LBIST test patterns from the eNVM pattern store into the systolic array. For each pattern it reads back every PE result and compares it against the stored expected answer. It sits between eNVM and the systolic array inside the hybrid BIST path, and runs when the top is in test mode with LBIST selected. Its per-PE fault map feeds the recovery/remapping logic.

Parameters:
SYSTOLIC_SIZE, 8, array dimension N (N x N PEs)
WEIGHT_WIDTH, 8, weight bits
ACTIVATION_WIDTH, 8, activation bits
PARTIAL_SUM_WIDTH, 19, partial-sum bits (WEIGHT_WIDTH+ACTIVATION_WIDTH+clog2(N))
SA_TEST_PATTERN_DEPTH, 12, number of SA patterns in eNVM
PATTERN_ADDR_WIDTH, 4, clog2(SA_TEST_PATTERN_DEPTH)
ADDR_WIDTH, 3, clog2(N), array row read address
ARRAY_LATENCY, 16, cycles from activation_valid until array results are readable

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin the SA test
busy  out  1  high while the test is running
done  out  1  one-cycle pulse when all patterns are finished
envm_rd_en  out  1  eNVM read strobe
envm_rd_addr  out  PATTERN_ADDR_WIDTH  pattern index
envm_weight  in  WEIGHT_WIDTH  weight; valid the cycle after envm_rd_en
envm_activation  in  ACTIVATION_WIDTH  activation; same timing as envm_weight
envm_partial_sum  in  PARTIAL_SUM_WIDTH  partial-sum input; same timing
envm_answer  in  PARTIAL_SUM_WIDTH  expected PE result; same timing
weight_valid  out  1  weight load strobe to the array
input_weight_flat  out  N*WEIGHT_WIDTH  weight broadcast to all columns
activation_valid  out  1  activation strobe to the array
input_activation_flat  out  N*ACTIVATION_WIDTH  activation broadcast to all rows
input_partial_sum_flat  out  N*PARTIAL_SUM_WIDTH  partial sum broadcast to all columns
rd_addr  out  ADDR_WIDTH  array result row select
partial_sum_outputs_flat  in  N*PARTIAL_SUM_WIDTH  row results; valid one cycle after rd_addr
fault_map  out  N*N  sticky per-PE fail flags; bit index = row*N+col
any_fault  out  1  OR-reduction of fault_map

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0: busy, done, envm_rd_en, envm_rd_addr, weight_valid, activation_valid, the three flat buses, rd_addr, fault_map, any_fault. Latched pattern registers are cleared.
- Reset asserted mid-test aborts the test immediately. done is not pulsed, and fault_map is cleared.
- FSM states: IDLE, FETCH, LATCH, LOAD_W, APPLY, WAIT, READ, NEXT, DONE.
- IDLE: on start=1, clear fault_map, set pattern index to 0, go to FETCH. busy is high in every state except IDLE.
- FETCH (1 cycle): envm_rd_en=1, envm_rd_addr=pattern index.
- LATCH (1 cycle): capture envm_weight, envm_activation, envm_partial_sum and envm_answer.
- LOAD_W (1 cycle): weight_valid=1. input_weight_flat = latched weight replicated N times.
- APPLY (1 cycle): activation_valid=1. Activation and partial sum are replicated N times on their buses. The buses hold these values until the next LOAD_W.
- WAIT: a counter runs ARRAY_LATENCY cycles, then goes to READ.
- READ (N+1 cycles): rd_addr steps through 0..N-1, one row per cycle. On each cycle after an address is issued, compare all N column words of partial_sum_outputs_flat bit-exactly against the latched answer. Set fault_map[row*N+col] on each mismatch. Bits are sticky: a bit once set stays set.
- NEXT (1 cycle): if pattern index equals SA_TEST_PATTERN_DEPTH-1, go to DONE. Otherwise increment the index and go to FETCH.
- DONE (1 cycle): done=1, then return to IDLE. fault_map holds its value until the next start or reset.
- Per-pattern time: 6+ARRAY_LATENCY+N cycles (30 at the defaults).
- Latency: done asserts exactly SA_TEST_PATTERN_DEPTH*(6+ARRAY_LATENCY+N)+1 cycles after the clock edge that samples start (361 at the defaults).
- start while busy is ignored. start coincident with DONE is ignored.
- Counters never wrap: the pattern index stops at DEPTH-1, and rd_addr returns to 0 in non-READ states.
- any_fault is registered and has the same timing as fault_map.

Test Plan:
- Fault-free array model (each PE returns W*A+P) with the default 12 patterns, start at cycle 0 → busy=1 from cycle 1; done pulses at cycle 361; fault_map=0, any_fault=0.
- Model corrupts PE (row3,col5) output bit 0 on pattern 7 only → fault_map has only bit 29 set and any_fault=1. The bit stays set through patterns 8-11 and after done.
- Column 2 stuck at 0 on all rows for every pattern whose answer ≠ 0 → fault_map bits 2, 10, 18, …, 58 set; all other bits clear.
- A second start pulse at cycle 50 and at the DONE cycle → no effect; done at 361 only, and envm_rd_addr sequence is 0..11 exactly once.
- rst_n low for 2 cycles during WAIT of pattern 4, with a fault already latched → all outputs 0 immediately, no done pulse. A new start then runs the full 361-cycle test.
- Run 1 with an injected fault, then run 2 with a clean model → fault_map clears on the start of run 2 and ends 0.

Source files
------------

// File: rtl/lbist_sa_sequencer.sv
// Stuck-at LBIST sequencer: streams eNVM patterns into the systolic array,
// reads back every PE result and accumulates a sticky per-PE fault map.
module lbist_sa_sequencer #(
  parameter int SYSTOLIC_SIZE         = 8,
  parameter int WEIGHT_WIDTH          = 8,
  parameter int ACTIVATION_WIDTH      = 8,
  parameter int PARTIAL_SUM_WIDTH     = 19,
  parameter int SA_TEST_PATTERN_DEPTH = 12,
  parameter int PATTERN_ADDR_WIDTH    = 4,
  parameter int ADDR_WIDTH            = 3,
  parameter int ARRAY_LATENCY         = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        envm_rd_en,
  output logic [PATTERN_ADDR_WIDTH-1:0]               envm_rd_addr,
  input  logic [WEIGHT_WIDTH-1:0]                     envm_weight,
  input  logic [ACTIVATION_WIDTH-1:0]                 envm_activation,
  input  logic [PARTIAL_SUM_WIDTH-1:0]                envm_partial_sum,
  input  logic [PARTIAL_SUM_WIDTH-1:0]                envm_answer,
  output logic                                        weight_valid,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]       input_weight_flat,
  output logic                                        activation_valid,
  output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]   input_activation_flat,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]  input_partial_sum_flat,
  output logic [ADDR_WIDTH-1:0]                       rd_addr,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0]  partial_sum_outputs_flat,
  output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0]      fault_map,
  output logic                                        any_fault
);

  localparam int N     = SYSTOLIC_SIZE;
  localparam int CNT_W = $clog2(ARRAY_LATENCY + 1);
  localparam logic [CNT_W-1:0]              LAT_LAST = CNT_W'(ARRAY_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]           RD_LAST  = (ADDR_WIDTH+1)'(N);
  localparam logic [ADDR_WIDTH:0]           RD_STEP  = (ADDR_WIDTH+1)'(N - 1);
  localparam logic [PATTERN_ADDR_WIDTH-1:0] PAT_LAST = PATTERN_ADDR_WIDTH'(SA_TEST_PATTERN_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_LOAD_W = 4'd3,
    S_APPLY  = 4'd4,
    S_WAIT   = 4'd5,
    S_READ   = 4'd6,
    S_NEXT   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [PATTERN_ADDR_WIDTH-1:0]         r_pat_idx;
  logic [PATTERN_ADDR_WIDTH-1:0]         w_pat_nxt;
  logic [CNT_W-1:0]                      r_wait_cnt;
  logic [ADDR_WIDTH:0]                   r_rd_cnt;
  logic [ACTIVATION_WIDTH-1:0]           r_activation;
  logic [PARTIAL_SUM_WIDTH-1:0]          r_partial_sum;
  logic [PARTIAL_SUM_WIDTH-1:0]          r_answer;
  logic                                  r_busy;
  logic                                  r_done;
  logic                                  r_envm_rd_en;
  logic [PATTERN_ADDR_WIDTH-1:0]         r_envm_rd_addr;
  logic                                  r_weight_valid;
  logic                                  r_activation_valid;
  logic [N*WEIGHT_WIDTH-1:0]             r_weight_flat;
  logic [N*ACTIVATION_WIDTH-1:0]         r_activation_flat;
  logic [N*PARTIAL_SUM_WIDTH-1:0]        r_partial_sum_flat;
  logic [ADDR_WIDTH-1:0]                 r_rd_addr;
  logic [N*N-1:0]                        r_fault_map;
  logic [N*N-1:0]                        w_fault_nxt;
  logic                                  r_any_fault;
  logic                                  w_start_ok;
  logic                                  w_cmp_en;
  logic [ADDR_WIDTH-1:0]                 w_row;

  // The IDLE cycle carrying the done pulse also refuses start.
  assign w_start_ok = start && (r_state == S_IDLE) && !r_done;
  assign w_cmp_en   = (r_state == S_READ) && (r_rd_cnt != '0);
  assign w_row      = ADDR_WIDTH'(r_rd_cnt - (ADDR_WIDTH+1)'(1));

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_start_ok ? S_FETCH : S_IDLE;
      S_FETCH:  w_state_nxt = S_LATCH;
      S_LATCH:  w_state_nxt = S_LOAD_W;
      S_LOAD_W: w_state_nxt = S_APPLY;
      S_APPLY:  w_state_nxt = S_WAIT;
      S_WAIT:   w_state_nxt = (r_wait_cnt == LAT_LAST) ? S_READ : S_WAIT;
      S_READ:   w_state_nxt = (r_rd_cnt == RD_LAST) ? S_NEXT : S_READ;
      S_NEXT:   w_state_nxt = (r_pat_idx == PAT_LAST) ? S_DONE : S_FETCH;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Pattern index: reset on accepted start, saturates at the last pattern
  always_comb begin
    w_pat_nxt = r_pat_idx;
    if (w_start_ok) begin
      w_pat_nxt = '0;
    end else if ((r_state == S_NEXT) && (r_pat_idx != PAT_LAST)) begin
      w_pat_nxt = r_pat_idx + PATTERN_ADDR_WIDTH'(1);
    end else begin
      w_pat_nxt = r_pat_idx;
    end
  end

  // Row results arrive one cycle after their address, so row = count-1
  always_comb begin
    w_fault_nxt = r_fault_map;
    if (w_start_ok) begin
      w_fault_nxt = '0;
    end else if (w_cmp_en) begin
      for (int c = 0; c < N; c++) begin
        w_fault_nxt[int'(w_row)*N + c] = r_fault_map[int'(w_row)*N + c] |
          (partial_sum_outputs_flat[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] != r_answer);
      end
    end else begin
      w_fault_nxt = r_fault_map;
    end
  end

  // State, counters and latched pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pat_idx     <= '0;
      r_wait_cnt    <= '0;
      r_rd_cnt      <= '0;
      r_activation  <= '0;
      r_partial_sum <= '0;
      r_answer      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pat_idx  <= w_pat_nxt;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
      r_rd_cnt   <= (r_state == S_READ) ? r_rd_cnt + (ADDR_WIDTH+1)'(1) : '0;
      if (r_state == S_LATCH) begin
        r_activation  <= envm_activation;
        r_partial_sum <= envm_partial_sum;
        r_answer      <= envm_answer;
      end
    end
  end

  // Registered outputs, timed so each strobe is high during its own state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_envm_rd_en       <= 1'b0;
      r_envm_rd_addr     <= '0;
      r_weight_valid     <= 1'b0;
      r_activation_valid <= 1'b0;
      r_weight_flat      <= '0;
      r_activation_flat  <= '0;
      r_partial_sum_flat <= '0;
      r_rd_addr          <= '0;
      r_fault_map        <= '0;
      r_any_fault        <= 1'b0;
    end else begin
      r_busy             <= (w_state_nxt != S_IDLE);
      r_done             <= (r_state == S_DONE);
      r_envm_rd_en       <= (w_state_nxt == S_FETCH);
      r_weight_valid     <= (w_state_nxt == S_LOAD_W);
      r_activation_valid <= (w_state_nxt == S_APPLY);
      if (w_state_nxt == S_FETCH) begin
        r_envm_rd_addr <= w_pat_nxt;
      end
      if (r_state == S_LATCH) begin
        r_weight_flat <= {N{envm_weight}};
      end
      if (r_state == S_LOAD_W) begin
        r_activation_flat  <= {N{r_activation}};
        r_partial_sum_flat <= {N{r_partial_sum}};
      end
      if ((r_state == S_READ) && (r_rd_cnt < RD_STEP)) begin
        r_rd_addr <= ADDR_WIDTH'(r_rd_cnt + (ADDR_WIDTH+1)'(1));
      end else begin
        r_rd_addr <= '0;
      end
      r_fault_map <= w_fault_nxt;
      r_any_fault <= |w_fault_nxt;
    end
  end

  assign busy                   = r_busy;
  assign done                   = r_done;
  assign envm_rd_en             = r_envm_rd_en;
  assign envm_rd_addr           = r_envm_rd_addr;
  assign weight_valid           = r_weight_valid;
  assign input_weight_flat      = r_weight_flat;
  assign activation_valid       = r_activation_valid;
  assign input_activation_flat  = r_activation_flat;
  assign input_partial_sum_flat = r_partial_sum_flat;
  assign rd_addr                = r_rd_addr;
  assign fault_map              = r_fault_map;
  assign any_fault              = r_any_fault;

endmodule
